// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the game countdown timer controller.
package timer_pkg;

  localparam int TIMER_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_GAME = 1'b1;

endpackage

// File: rtl/timer_ctrl_if.sv
// Load/control/status bundle between the timer controller and its two loaders.
interface timer_ctrl_if;
  import timer_pkg::*;

  logic               cpu_req;
  logic [TIMER_W-1:0] cpu_wdata;
  logic               game_req;
  logic [TIMER_W-1:0] game_wdata;
  logic               pause;
  logic               resume;
  logic               irq_ack;
  logic               grant_cpu;
  logic               grant_game;
  logic               owner;
  logic [TIMER_W-1:0] value;
  logic [1:0]         state;
  logic               irq;

  modport master (
    output cpu_req, cpu_wdata, game_req, game_wdata, pause, resume, irq_ack,
    input  grant_cpu, grant_game, owner, value, state, irq
  );

  modport slave (
    input  cpu_req, cpu_wdata, game_req, game_wdata, pause, resume, irq_ack,
    output grant_cpu, grant_game, owner, value, state, irq
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk_cpu into a one-cycle tick enable every DIV enabled cycles.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk_cpu,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear wins, otherwise count/wrap only while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Shared countdown timer: fixed-priority load arbitration, run/pause/expire FSM
// and sticky expiry interrupt, all on the single clk_cpu domain.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter bit GAME_PREEMPT = 1'b0
) (
  input  logic         clk_cpu,
  input  logic         rst_n,
  timer_ctrl_if.slave  bus
);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] value_q, value_d;
  logic               owner_q, owner_d;
  logic               irq_q,   irq_d;

  logic               game_blocked_s;
  logic               grant_cpu_s;
  logic               grant_game_s;
  logic               load_s;
  logic [TIMER_W-1:0] load_val_s;
  logic               pause_ev_s;
  logic               resume_ev_s;
  logic               presc_en_s;
  logic               tick_s;
  logic               expire_s;

  // Grants are combinational so the accepted load lands on the same edge the grant is seen.
  always_comb begin
    game_blocked_s = !GAME_PREEMPT && (owner_q == OWNER_CPU) &&
                     ((state_q == ST_RUN) || (state_q == ST_PAUSE));
    grant_cpu_s    = bus.cpu_req;
    grant_game_s   = bus.game_req && !bus.cpu_req && !game_blocked_s;
    load_s         = grant_cpu_s || grant_game_s;
    load_val_s     = grant_cpu_s ? bus.cpu_wdata : bus.game_wdata;
    pause_ev_s     = bus.pause && !bus.resume && (state_q == ST_RUN);
    resume_ev_s    = bus.resume && !bus.pause && (state_q == ST_PAUSE);
    presc_en_s     = (state_q == ST_RUN) && !load_s && !pause_ev_s;
  end

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_presc (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .en      (presc_en_s),
    .clr     (load_s),
    .tick    (tick_s)
  );

  // next-state: load > pause/resume > tick; irq set beats ack
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    owner_d  = owner_q;
    expire_s = 1'b0;
    if (load_s) begin
      value_d = load_val_s;
      owner_d = grant_cpu_s ? OWNER_CPU : OWNER_GAME;
      state_d = (load_val_s != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause_ev_s) begin
            state_d = ST_PAUSE;
          end else if (tick_s) begin
            if (value_q > TIMER_W'(1)) begin
              value_d = value_q - TIMER_W'(1);
            end else begin
              value_d  = '0;
              state_d  = ST_EXPIRED;
              expire_s = 1'b1;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (resume_ev_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_EXPIRED: state_d = ST_EXPIRED;
        ST_IDLE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
    if (expire_s) begin
      irq_d = 1'b1;
    end else if (bus.irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // state, count, owner and interrupt registers
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      owner_q <= OWNER_CPU;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      owner_q <= owner_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.grant_cpu  = grant_cpu_s;
  assign bus.grant_game = grant_game_s;
  assign bus.owner      = owner_q;
  assign bus.value      = value_q;
  assign bus.state      = state_q;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with TICK_DIV=4; dut_a blocks game
// preemption, dut_b allows it.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int TD = 4;

  logic clk_cpu = 1'b0;
  logic rst_n   = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  timer_ctrl_if a_if ();
  timer_ctrl_if b_if ();

  timer_ctrl #(.TICK_DIV(TD), .GAME_PREEMPT(1'b0)) dut_a (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .bus     (a_if.slave)
  );

  timer_ctrl #(.TICK_DIV(TD), .GAME_PREEMPT(1'b1)) dut_b (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .bus     (b_if.slave)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_cpu);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_if.cpu_req = 1'b0; a_if.cpu_wdata = 32'd0; a_if.game_req = 1'b0; a_if.game_wdata = 32'd0;
    a_if.pause = 1'b0; a_if.resume = 1'b0; a_if.irq_ack = 1'b0;
    b_if.cpu_req = 1'b0; b_if.cpu_wdata = 32'd0; b_if.game_req = 1'b0; b_if.game_wdata = 32'd0;
    b_if.pause = 1'b0; b_if.resume = 1'b0; b_if.irq_ack = 1'b0;

    // power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_value", a_if.value, 32'd0);
    chk("rst_state", {30'd0, a_if.state}, 32'd0);
    chk("rst_owner", {31'd0, a_if.owner}, 32'd0);
    chk("rst_irq", {31'd0, a_if.irq}, 32'd0);
    chk("rst_gcpu", {31'd0, a_if.grant_cpu}, 32'd0);
    chk("rst_ggame", {31'd0, a_if.grant_game}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // 1: asynchronous reset in the middle of a run
    a_if.cpu_req = 1'b1; a_if.cpu_wdata = 32'd7;
    #1;
    chk("t1_grant", {31'd0, a_if.grant_cpu}, 32'd1);
    cyc(1);
    a_if.cpu_req = 1'b0;
    chk("t1_val7", a_if.value, 32'd7);
    chk("t1_run", {30'd0, a_if.state}, 32'd1);
    cyc(2);
    chk("t1_val7b", a_if.value, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_val", a_if.value, 32'd0);
    chk("t1_rst_state", {30'd0, a_if.state}, 32'd0);
    chk("t1_rst_irq", {31'd0, a_if.irq}, 32'd0);
    #1 rst_n = 1'b1;
    cyc(1);

    // 2: CPU load 3 counts down and expires, then irq_ack
    a_if.cpu_req = 1'b1; a_if.cpu_wdata = 32'd3;
    #1;
    chk("t2_gcpu", {31'd0, a_if.grant_cpu}, 32'd1);
    chk("t2_ggame", {31'd0, a_if.grant_game}, 32'd0);
    cyc(1);
    a_if.cpu_req = 1'b0;
    chk("t2_load", a_if.value, 32'd3);
    chk("t2_run", {30'd0, a_if.state}, 32'd1);
    chk("t2_owner", {31'd0, a_if.owner}, 32'd0);
    cyc(3);
    chk("t2_l3", a_if.value, 32'd3);
    cyc(1);
    chk("t2_l4", a_if.value, 32'd2);
    cyc(4);
    chk("t2_l8", a_if.value, 32'd1);
    cyc(3);
    chk("t2_l11", a_if.value, 32'd1);
    chk("t2_l11_irq", {31'd0, a_if.irq}, 32'd0);
    cyc(1);
    chk("t2_l12_val", a_if.value, 32'd0);
    chk("t2_l12_state", {30'd0, a_if.state}, 32'd3);
    chk("t2_l12_irq", {31'd0, a_if.irq}, 32'd1);
    cyc(2);
    chk("t2_l14_irq", {31'd0, a_if.irq}, 32'd1);
    a_if.irq_ack = 1'b1;
    cyc(1);
    a_if.irq_ack = 1'b0;
    chk("t2_ack_irq", {31'd0, a_if.irq}, 32'd0);
    chk("t2_ack_val", a_if.value, 32'd0);
    chk("t2_ack_state", {30'd0, a_if.state}, 32'd3);

    // 3: simultaneous requests, CPU wins; game blocked until expiry
    a_if.cpu_req = 1'b1; a_if.cpu_wdata = 32'd5;
    a_if.game_req = 1'b1; a_if.game_wdata = 32'd9;
    #1;
    chk("t3_gcpu", {31'd0, a_if.grant_cpu}, 32'd1);
    chk("t3_ggame", {31'd0, a_if.grant_game}, 32'd0);
    cyc(1);
    a_if.cpu_req = 1'b0;
    #1;
    chk("t3_val", a_if.value, 32'd5);
    chk("t3_owner", {31'd0, a_if.owner}, 32'd0);
    chk("t3_blocked", {31'd0, a_if.grant_game}, 32'd0);
    cyc(19);
    chk("t3_l19_blocked", {31'd0, a_if.grant_game}, 32'd0);
    chk("t3_l19_val", a_if.value, 32'd1);
    cyc(1);
    chk("t3_exp_state", {30'd0, a_if.state}, 32'd3);
    chk("t3_exp_ggame", {31'd0, a_if.grant_game}, 32'd1);
    cyc(1);
    a_if.game_req = 1'b0;
    chk("t3_gval", a_if.value, 32'd9);
    chk("t3_gowner", {31'd0, a_if.owner}, 32'd1);
    chk("t3_gstate", {30'd0, a_if.state}, 32'd1);
    chk("t3_girq", {31'd0, a_if.irq}, 32'd1);
    a_if.irq_ack = 1'b1;
    cyc(1);
    a_if.irq_ack = 1'b0;
    chk("t3_ack", {31'd0, a_if.irq}, 32'd0);

    // 4: pause freezes value and prescaler, resume continues
    a_if.cpu_req = 1'b1; a_if.cpu_wdata = 32'd7;
    cyc(1);
    a_if.cpu_req = 1'b0;
    chk("t4_load", a_if.value, 32'd7);
    chk("t4_owner", {31'd0, a_if.owner}, 32'd0);
    cyc(4);
    chk("t4_val6", a_if.value, 32'd6);
    cyc(2);
    a_if.pause = 1'b1;
    cyc(1);
    a_if.pause = 1'b0;
    chk("t4_paused", {30'd0, a_if.state}, 32'd2);
    cyc(20);
    chk("t4_frozen_val", a_if.value, 32'd6);
    chk("t4_frozen_state", {30'd0, a_if.state}, 32'd2);
    a_if.resume = 1'b1;
    cyc(1);
    a_if.resume = 1'b0;
    chk("t4_resumed", {30'd0, a_if.state}, 32'd1);
    chk("t4_r0", a_if.value, 32'd6);
    cyc(1);
    chk("t4_r1", a_if.value, 32'd6);
    cyc(1);
    chk("t4_r2", a_if.value, 32'd5);
    a_if.pause = 1'b1; a_if.resume = 1'b1;
    cyc(1);
    a_if.pause = 1'b0; a_if.resume = 1'b0;
    chk("t4_both_ignored", {30'd0, a_if.state}, 32'd1);

    // 5: expiry coinciding with irq_ack, then load of zero
    a_if.cpu_req = 1'b1; a_if.cpu_wdata = 32'd1;
    cyc(1);
    a_if.cpu_req = 1'b0;
    chk("t5_load1", a_if.value, 32'd1);
    cyc(3);
    a_if.irq_ack = 1'b1;
    cyc(1);
    a_if.irq_ack = 1'b0;
    chk("t5_irq_set_wins", {31'd0, a_if.irq}, 32'd1);
    chk("t5_exp", {30'd0, a_if.state}, 32'd3);
    a_if.cpu_req = 1'b1; a_if.cpu_wdata = 32'd0;
    cyc(1);
    a_if.cpu_req = 1'b0;
    chk("t5_idle", {30'd0, a_if.state}, 32'd0);
    chk("t5_zero", a_if.value, 32'd0);
    chk("t5_irq_kept", {31'd0, a_if.irq}, 32'd1);
    cyc(8);
    chk("t5_no_dec", a_if.value, 32'd0);
    chk("t5_still_idle", {30'd0, a_if.state}, 32'd0);

    // 6: game preempts a CPU-owned run when preemption is enabled
    b_if.cpu_req = 1'b1; b_if.cpu_wdata = 32'd10;
    cyc(1);
    b_if.cpu_req = 1'b0;
    chk("t6_load10", b_if.value, 32'd10);
    chk("t6_owner_cpu", {31'd0, b_if.owner}, 32'd0);
    cyc(2);
    b_if.game_req = 1'b1; b_if.game_wdata = 32'd2;
    #1;
    chk("t6_ggame", {31'd0, b_if.grant_game}, 32'd1);
    chk("t6_gcpu", {31'd0, b_if.grant_cpu}, 32'd0);
    cyc(1);
    b_if.game_req = 1'b0;
    chk("t6_val2", b_if.value, 32'd2);
    chk("t6_owner_game", {31'd0, b_if.owner}, 32'd1);
    cyc(3);
    chk("t6_g3", b_if.value, 32'd2);
    cyc(1);
    chk("t6_g4", b_if.value, 32'd1);
    cyc(3);
    chk("t6_g7", b_if.value, 32'd1);
    chk("t6_g7_state", {30'd0, b_if.state}, 32'd1);
    cyc(1);
    chk("t6_g8_val", b_if.value, 32'd0);
    chk("t6_g8_state", {30'd0, b_if.state}, 32'd3);
    chk("t6_g8_irq", {31'd0, b_if.irq}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Controller and arbiter for the shared 32-bit countdown timer used by the game logic.
- Replaces the gated-clock "1 Hz vs CPU clock" scheme with one clock, `clk_cpu`, and an internal prescaler tick-enable.
- Arbitrates load requests from the CPU store path and the game FSM, and sequences run/pause/expire.
- Raises a sticky expiry interrupt, held until acknowledged.

Parameters:
- TICK_DIV, 50_000_000: clk_cpu cycles per countdown decrement (1 Hz at 50 MHz); must be >= 2.
- GAME_PREEMPT, 0: 1 lets a game load override a running or paused CPU-owned countdown; 0 blocks it.

Ports:
- clk_cpu  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU load request; level, held until granted.
- cpu_wdata  in  32  CPU load value.
- game_req  in  1  game FSM load request; level, held until granted.
- game_wdata  in  32  game load value.
- pause  in  1  pulse; freezes a running countdown.
- resume  in  1  pulse; restarts a paused countdown.
- irq_ack  in  1  pulse; clears irq.
- grant_cpu  out  1  one-cycle pulse: CPU load accepted this cycle.
- grant_game  out  1  one-cycle pulse: game load accepted this cycle.
- owner  out  1  last accepted loader: 0 = CPU, 1 = game.
- value  out  32  current count, registered.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- irq  out  1  sticky expiry flag.

Behaviour:
- Reset (async, rst_n=0): value=0, state=IDLE, owner=0, irq=0, grants=0, prescaler=0. Normal operation resumes on the first clk_cpu edge after release.
- Arbitration, fixed priority:
  - cpu_req is always granted.
  - game_req is granted only when cpu_req=0, and additionally, if GAME_PREEMPT=0, not while (owner=0 and state is RUN or PAUSE).
  - A blocked requester keeps its request high; no queueing.
  - Grant pulse and load occur in the same cycle; new value is visible the next cycle.
- Load (any state, including preempting RUN/PAUSE/EXPIRED):
  - value <= wdata; owner <= requester; prescaler <= 0.
  - state <= RUN if wdata != 0, else IDLE.
  - Loads never touch irq.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds in other states.
  - tick asserts when prescaler == TICK_DIV-1, then wraps to 0.
  - First decrement therefore occurs exactly TICK_DIV cycles after the load edge.
- RUN, on tick:
  - value > 1: value <= value-1.
  - value == 1: value <= 0, state <= EXPIRED, irq <= 1.
- Pause/resume:
  - pause in RUN -> PAUSE; prescaler and value frozen.
  - resume in PAUSE -> RUN; prescaler continues from its frozen count.
  - pause outside RUN and resume outside PAUSE are ignored.
  - pause and resume in the same cycle: both ignored.
- EXPIRED holds value=0 until the next load. There is no IDLE transition from EXPIRED other than a load of 0.
- Priority within one cycle: load > pause/resume > tick. A load coinciding with a tick discards the tick.
- irq:
  - Set on the expiry transition; cleared by irq_ack.
  - Simultaneous expiry and irq_ack leaves irq=1 (set wins).
- Value never underflows; 0 is never decremented.
- Widths: 32-bit unsigned count; prescaler width $clog2(TICK_DIV).

Decomposition:
- Package timer_pkg holds:
  - the state encoding localparams (ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED);
  - OWNER_CPU/OWNER_GAME;
  - TIMER_W=32.
- One natural sub-module, tick_prescaler (parameter DIV, inputs en and clr, output tick pulse), instantiated once.
- Arbitration and the state FSM stay in timer_ctrl.

Test Plan (TICK_DIV=4):
1. Reset mid-RUN (value=7): assert rst_n=0 between edges -> value=0, state=IDLE, irq=0 immediately, without waiting for a clock edge.
2. CPU loads 3 -> grant_cpu pulse at load edge; value 3->2->1->0 at edges +4, +8, +12; state EXPIRED and irq=1 at +12. irq_ack at +15 -> irq=0, value stays 0.
3. cpu_req and game_req both high, loading 5 and 9 -> grant_cpu only, value=5, owner=0. With GAME_PREEMPT=0 and game_req held -> no grant_game until expiry. After expiry -> grant_game, value=9, owner=1.
4. Running at value=6: pause 2 cycles after a tick -> value frozen at 6 for 20 cycles. Resume -> next decrement to 5 two cycles after resume.
5. Expiry edge with irq_ack high -> irq=1. Load of 0 -> state IDLE, no irq change, no decrement.
6. GAME_PREEMPT=1, CPU-owned RUN at value=10: game load 2 -> grant_game, value=2, owner=1, prescaler cleared, expiry 8 cycles later.
